// File: rtl/wide_fifo.sv
`default_nettype none
// ============================================================================
// Module      : dual_port_memory / wide_fifo
// Description : dual_port_memory - simple dual-port block RAM, one write port,
//               one registered read port (one-cycle read latency), no reset
//               on the array or the read register.
//               wide_fifo - single-clock 80-bit first-word-fall-through FIFO
//               built on dual_port_memory. Adds write/read pointers, a RAM
//               occupancy count, a one-deep read prefetch and a 2-entry
//               output stage so both sides get valid/ready handshakes and
//               one word per cycle is sustained.
//
// wide_fifo ports:
//   clock     in   system clock (both RAM ports)
//   reset_n   in   asynchronous active-low reset
//   in_data   in   write word
//   in_valid  in   producer has a word
//   in_ready  out  FIFO can accept (RAM not full)
//   out_data  out  head word, meaningful while out_valid=1
//   out_valid out  head word present
//   out_ready in   consumer takes the head word
//   level     out  words held (RAM + in-flight read + output stage)
//   overflow  out  sticky: in_valid seen while in_ready=0
//
// Revision    : 1.0 - initial release
// ============================================================================

module dual_port_memory #(
  parameter int WIDTH      = 80,
  parameter int DEPTH      = 512,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  write_clock,
  input  logic                  write_clock_enable,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [WIDTH-1:0]      write_data,
  input  logic                  read_clock,
  input  logic                  read_clock_enable,
  input  logic                  read_enable,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  output logic [WIDTH-1:0]      read_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge write_clock) begin
    if (write_clock_enable && write_enable) begin
      mem_q[write_addr] <= write_data;
    end
  end

  // Registered read: data for read_addr appears after the next read_clock edge.
  always_ff @(posedge read_clock) begin
    if (read_clock_enable && read_enable) begin
      read_data <= mem_q[read_addr];
    end
  end

endmodule

module wide_fifo #(
  parameter int WIDTH       = 80,
  parameter int DEPTH       = 512,
  parameter int LEVEL_WIDTH = $clog2(DEPTH + 3)
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LEVEL_WIDTH-1:0] level,
  output logic                   overflow
);

  localparam int ADDR_WIDTH  = $clog2(DEPTH);
  localparam int COUNT_WIDTH = ADDR_WIDTH + 1;   // holds 0..DEPTH inclusive

  // --------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // --------------------------------------------------------------------------
  generate
    if (WIDTH != 80) begin : g_bad_width
      $error("wide_fifo: WIDTH must be 80 to match dual_port_memory");
    end
    if ((DEPTH < 2) || (DEPTH > 512) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("wide_fifo: DEPTH must be a power of two in 2..512");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0]  wr_ptr_q,       wr_ptr_d;
  logic [ADDR_WIDTH-1:0]  rd_ptr_q,       rd_ptr_d;
  logic [COUNT_WIDTH-1:0] ram_count_q,    ram_count_d;
  logic                   read_pending_q, read_pending_d;
  logic [1:0]             stage_count_q,  stage_count_d;
  logic [WIDTH-1:0]       stage0_q,       stage0_d;
  logic [WIDTH-1:0]       stage1_q,       stage1_d;
  logic                   overflow_q,     overflow_d;

  // --------------------------------------------------------------------------
  // Handshakes and read issue
  // --------------------------------------------------------------------------
  logic             push;
  logic             pop;
  logic             rd_issue;
  logic [2:0]       inflight_after_pop;
  logic [1:0]       capture_slot;
  logic [WIDTH-1:0] ram_read_data;

  always_comb begin
    in_ready  = (ram_count_q < COUNT_WIDTH'(DEPTH));
    out_valid = (stage_count_q != 2'd0);
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;

    // Words already committed to the stage (held or arriving next edge),
    // minus the one leaving this cycle. A pop implies stage_count >= 1, so
    // this cannot underflow. Keeping it below 2 guarantees the prefetched
    // word always finds a free slot.
    inflight_after_pop = {1'b0, stage_count_q} + {2'b00, read_pending_q}
                       - {2'b00, pop};

    // Only the registered ram_count is used: a word written this cycle is
    // not counted yet, so the read address never equals the write address.
    rd_issue = (ram_count_q != '0) && (inflight_after_pop < 3'd2);

    // Slot the returning read lands in, after this cycle's pop shift.
    capture_slot = stage_count_q - {1'b0, pop};
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    ram_count_d    = ram_count_q;
    read_pending_d = rd_issue;
    stage_count_d  = stage_count_q;
    stage0_d       = stage0_q;
    stage1_d       = stage1_q;
    overflow_d     = overflow_q | (in_valid & ~in_ready);

    // DEPTH is a power of two, so natural pointer rollover is modulo DEPTH.
    if (push) begin
      wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    end
    if (rd_issue) begin
      rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
    end

    ram_count_d = ram_count_q + COUNT_WIDTH'(push) - COUNT_WIDTH'(rd_issue);

    // Pop shifts entry 1 down to entry 0; the capture below may then
    // overwrite whichever slot is first free.
    if (pop) begin
      stage0_d = stage1_q;
    end

    if (read_pending_q) begin
      if (capture_slot == 2'd0) begin
        stage0_d = ram_read_data;
      end else begin
        stage1_d = ram_read_data;
      end
    end

    stage_count_d = stage_count_q - {1'b0, pop} + {1'b0, read_pending_q};
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  // Clearing read_pending on reset is what discards a RAM read that is in
  // flight when reset hits; the RAM output register itself is not reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      ram_count_q    <= '0;
      read_pending_q <= 1'b0;
      stage_count_q  <= 2'd0;
      stage0_q       <= '0;
      stage1_q       <= '0;
      overflow_q     <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      ram_count_q    <= ram_count_d;
      read_pending_q <= read_pending_d;
      stage_count_q  <= stage_count_d;
      stage0_q       <= stage0_d;
      stage1_q       <= stage1_d;
      overflow_q     <= overflow_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  always_comb begin
    out_data = stage0_q;
    overflow = overflow_q;
    level    = LEVEL_WIDTH'(ram_count_q) + LEVEL_WIDTH'(read_pending_q)
             + LEVEL_WIDTH'(stage_count_q);
  end

  // --------------------------------------------------------------------------
  // Storage
  // --------------------------------------------------------------------------
  dual_port_memory #(
    .WIDTH      (WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .write_clock        (clock),
    .write_clock_enable (1'b1),
    .write_enable       (push),
    .write_addr         (wr_ptr_q),
    .write_data         (in_data),
    .read_clock         (clock),
    .read_clock_enable  (1'b1),
    .read_enable        (rd_issue),
    .read_addr          (rd_ptr_q),
    .read_data          (ram_read_data)
  );

endmodule

`default_nettype wire

// File: tb/tb_wide_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_wide_fifo
// Description : Directed self-checking bench for wide_fifo. Inputs are driven
//               and outputs observed on the falling clock edge; the DUT
//               state changes on the rising edge.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_wide_fifo;

  localparam int WIDTH = 80;
  localparam int DEPTH = 512;
  localparam int LW    = 10;

  logic             clock = 1'b0;
  logic             reset_n = 1'b1;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [LW-1:0]    level;
  logic             overflow;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] model_q[$];

  always #5 clock = ~clock;

  wide_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LEVEL_WIDTH(LW)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level),
    .overflow  (overflow)
  );

  function automatic logic [WIDTH-1:0] word(input int k);
    logic [31:0] kk;
    kk = k;
    return {16'hC0DE, kk, kk * 32'd7 + 32'd3};
  endfunction

  // --------------------------------------------------------------------------
  task automatic test_reset();
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (level !== '0) begin errors++; $display("FAIL reset_level: got %0d expected 0", level); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  // --------------------------------------------------------------------------
  task automatic test_single();
    logic [WIDTH-1:0] v;
    v = 80'h1234_5678_9ABC_DEF0_1111;
    in_valid = 1'b1; in_data = v;
    @(negedge clock);                         // edge 0 done
    in_valid = 1'b0;
    checks++; if (level !== 10'd1) begin errors++; $display("FAIL single_level_e0: got %0d expected 1", level); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_valid_e0: got %b expected 0", out_valid); end
    @(negedge clock);                         // edge 1 done
    checks++; if (level !== 10'd1) begin errors++; $display("FAIL single_level_e1: got %0d expected 1", level); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_valid_e1: got %b expected 0", out_valid); end
    @(negedge clock);                         // edge 2 done
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid_e2: got %b expected 1", out_valid); end
    checks++; if (out_data !== v) begin errors++; $display("FAIL single_data: got %h expected %h", out_data, v); end
    checks++; if (level !== 10'd1) begin errors++; $display("FAIL single_level_e2: got %0d expected 1", level); end
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    checks++; if (level !== 10'd0) begin errors++; $display("FAIL single_level_pop: got %0d expected 0", level); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_valid_pop: got %b expected 0", out_valid); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_stream();
    int sent, rcvd, cyc, first;
    bit started;
    sent = 0; rcvd = 0; cyc = 0; first = -1; started = 1'b0;
    while (rcvd < 1000 && cyc < 1200) begin
      in_valid  = (sent < 1000);
      in_data   = word(sent);
      out_ready = 1'b1;
      checks++; if (int'(level) != sent - rcvd) begin errors++; $display("FAIL stream_level cyc %0d: got %0d expected %0d", cyc, level, sent - rcvd); end
      if (out_valid) begin
        if (!started) first = cyc;
        started = 1'b1;
        checks++; if (out_data !== word(rcvd)) begin errors++; $display("FAIL stream_data #%0d: got %h expected %h", rcvd, out_data, word(rcvd)); end
        rcvd++;
      end else if (started) begin
        checks++; errors++; $display("FAIL stream_bubble cyc %0d: got out_valid 0 expected 1", cyc);
      end
      if (in_valid) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready cyc %0d: got 0 expected 1", cyc); end
        else sent++;
      end
      cyc++;
      @(negedge clock);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (rcvd != 1000) begin errors++; $display("FAIL stream_count: got %0d expected 1000", rcvd); end
    checks++; if (first != 3) begin errors++; $display("FAIL stream_first_valid: got cycle %0d expected 3", first); end
    checks++; if (level !== 10'd0) begin errors++; $display("FAIL stream_end_level: got %0d expected 0", level); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_level_one();
    int nxt, pops;
    model_q.delete();
    in_valid = 1'b1; in_data = word(5000); model_q.push_back(word(5000));
    @(negedge clock);
    in_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    nxt = 5001; pops = 0;
    for (int i = 0; i < 100; i++) begin
      checks++; if (level !== 10'd1) begin errors++; $display("FAIL lvl1_level cyc %0d: got %0d expected 1", i, level); end
      if (out_valid) begin
        checks++; if (out_data !== model_q[0]) begin errors++; $display("FAIL lvl1_data cyc %0d: got %h expected %h", i, out_data, model_q[0]); end
        void'(model_q.pop_front());
        out_ready = 1'b1; in_valid = 1'b1; in_data = word(nxt);
        model_q.push_back(word(nxt)); nxt++; pops++;
      end else begin
        out_ready = 1'b0; in_valid = 1'b0;
      end
      @(negedge clock);
    end
    out_ready = 1'b0; in_valid = 1'b0;
    // Each pushed word needs 3 cycles (RAM, read, stage) to reach the head.
    checks++; if (pops != 34) begin errors++; $display("FAIL lvl1_pops: got %0d expected 34", pops); end
    for (int i = 0; i < 4 && !out_valid; i++) @(negedge clock);
    checks++; if (out_data !== model_q[0]) begin errors++; $display("FAIL lvl1_tail: got %h expected %h", out_data, model_q[0]); end
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    model_q.delete();
    checks++; if (level !== 10'd0) begin errors++; $display("FAIL lvl1_drained: got %0d expected 0", level); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_random();
    int k, cyc;
    bit stall_prev;
    logic [WIDTH-1:0] data_prev;
    model_q.delete();
    k = 10000; stall_prev = 1'b0; data_prev = '0;
    for (cyc = 0; cyc < 20000; cyc++) begin
      checks++; if (int'(level) != model_q.size()) begin errors++; $display("FAIL rand_level cyc %0d: got %0d expected %0d", cyc, level, model_q.size()); end
      if (stall_prev) begin
        checks++; if (out_valid !== 1'b1 || out_data !== data_prev) begin errors++; $display("FAIL rand_stable cyc %0d: got %b/%h expected 1/%h", cyc, out_valid, out_data, data_prev); end
      end
      if (model_q.size() < DEPTH) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rand_in_ready cyc %0d: got 0 expected 1", cyc); end
      end
      in_valid  = ($urandom_range(0, 1) == 1);
      out_ready = ($urandom_range(0, 1) == 1);
      in_data   = word(k);
      if (out_valid && out_ready) begin
        checks++; if (model_q.size() == 0 || out_data !== model_q[0]) begin errors++; $display("FAIL rand_data cyc %0d: got %h expected %h", cyc, out_data, (model_q.size() != 0) ? model_q[0] : '0); end
        if (model_q.size() != 0) void'(model_q.pop_front());
      end
      if (in_valid && in_ready) begin
        model_q.push_back(word(k)); k++;
      end
      stall_prev = out_valid && !out_ready;
      data_prev  = out_data;
      @(negedge clock);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    cyc = 0;
    while (model_q.size() != 0 && cyc < 200) begin
      if (out_valid) begin
        checks++; if (out_data !== model_q[0]) begin errors++; $display("FAIL rand_drain: got %h expected %h", out_data, model_q[0]); end
        void'(model_q.pop_front());
      end
      cyc++;
      @(negedge clock);
    end
    out_ready = 1'b0;
    checks++; if (level !== 10'd0) begin errors++; $display("FAIL rand_drain_level: got %0d expected 0 (left %0d)", level, model_q.size()); end
    model_q.delete();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_fill_overflow();
    int sent, rcvd, cyc;
    sent = 0; out_ready = 1'b0;
    for (cyc = 0; cyc < 600; cyc++) begin
      if (!in_ready) break;
      in_valid = 1'b1; in_data = word(sent); sent++;
      @(negedge clock);
    end
    in_valid = 1'b0;
    checks++; if (sent != DEPTH + 2) begin errors++; $display("FAIL fill_accepted: got %0d expected %0d", sent, DEPTH + 2); end
    checks++; if (level !== 10'd514) begin errors++; $display("FAIL fill_level: got %0d expected 514", level); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready: got %b expected 0", in_ready); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fill_overflow_pre: got %b expected 0", overflow); end
    @(negedge clock);
    in_valid = 1'b1; in_data = word(9999);
    @(negedge clock);
    in_valid = 1'b0;
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL fill_overflow_set: got %b expected 1", overflow); end
    checks++; if (level !== 10'd514) begin errors++; $display("FAIL fill_level_after_ovf: got %0d expected 514", level); end
    out_ready = 1'b1; rcvd = 0;
    for (cyc = 0; cyc < 700 && rcvd < DEPTH + 2; cyc++) begin
      if (out_valid) begin
        checks++; if (out_data !== word(rcvd)) begin errors++; $display("FAIL fill_drain #%0d: got %h expected %h", rcvd, out_data, word(rcvd)); end
        rcvd++;
      end
      @(negedge clock);
    end
    out_ready = 1'b0;
    checks++; if (rcvd != DEPTH + 2) begin errors++; $display("FAIL fill_drain_count: got %0d expected 514", rcvd); end
    checks++; if (level !== 10'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL fill_empty: got level %0d valid %b expected 0/0", level, out_valid); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL fill_overflow_sticky: got %b expected 1", overflow); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset_mid();
    logic [WIDTH-1:0] v;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_data = word(700 + i);
      @(negedge clock);
    end
    // One pop with no push: the freed slot triggers a read, leaving one in flight.
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    checks++; if (level !== 10'd7) begin errors++; $display("FAIL mid_level_pre: got %0d expected 7", level); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || level !== '0 || in_ready !== 1'b1 || overflow !== 1'b0 || out_data !== '0) begin
      errors++; $display("FAIL mid_reset_outputs: got valid %b level %0d ready %b ovf %b data %h expected 0/0/1/0/0", out_valid, level, in_ready, overflow, out_data);
    end
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    checks++; if (level !== '0 || out_valid !== 1'b0) begin errors++; $display("FAIL mid_post_reset_empty: got level %0d valid %b expected 0/0", level, out_valid); end
    v = 80'hFEED_0000_CAFE_0000_BEEF;
    in_valid = 1'b1; in_data = v;
    @(negedge clock);
    in_valid = 1'b0;
    @(negedge clock);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_no_stale: got out_valid %b expected 0", out_valid); end
    @(negedge clock);
    checks++; if (out_valid !== 1'b1 || out_data !== v || level !== 10'd1) begin errors++; $display("FAIL mid_first_word: got %b/%h/%0d expected 1/%h/1", out_valid, out_data, level, v); end
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || level !== 10'd0) begin errors++; $display("FAIL mid_final_empty: got %b/%0d expected 0/0", out_valid, level); end
  endtask

  // --------------------------------------------------------------------------
  initial begin
    test_reset();
    test_single();
    test_stream();
    test_level_one();
    test_random();
    test_fill_overflow();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
